// File: rtl/binary_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : binary_multiplier_pkg
// Brief    : Shared FSM state type and counter sizing for binary_multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package binary_multiplier_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mult_state_t;

    // Iteration counter must be able to represent 0..WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : binary_multiplier_pkg
`default_nettype wire

// File: rtl/binary_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : binary_multiplier
// Brief    : Sequential unsigned radix-2 shift-and-add multiplier with
//            start/busy/done handshake and a registered, held Product.
//            Optional macro BINARY_MULTIPLIER_EARLY_TERM_EN ends an operation
//            as soon as the remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module binary_multiplier
    import binary_multiplier_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int                  c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0]  c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    mult_state_t           r_state;
    mult_state_t           w_state_next;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [2*WIDTH-1:0]    r_acc;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [2*WIDTH-1:0]    r_product;
    logic                  r_done;

    logic [2*WIDTH-1:0]    w_acc_next;
    logic [WIDTH-1:0]      w_mplier_next;
    logic                  w_last;

    assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mplier_next = r_mplier >> 1;

`ifdef BINARY_MULTIPLIER_EARLY_TERM_EN
    // Once the shifted multiplier is empty no further partial products remain.
    assign w_last = (r_cnt == c_last_cnt) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == c_last_cnt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, A};
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_product <= w_acc_next;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = r_done;
    assign Product = r_product;

endmodule : binary_multiplier
`default_nettype wire

// File: tb/tb_binary_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_multiplier
// Brief    : Self-checking bench for binary_multiplier (WIDTH=4): directed
//            table, random operands against an arithmetic model, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_binary_multiplier;

    localparam int WIDTH = 4;
    localparam int PW    = 2 * WIDTH;

    logic            clk;
    logic            rst;
    logic            start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic            busy;
    logic            done;
    logic [PW-1:0]   Product;

    int checks;
    int errors;
    logic [PW-1:0] last_prod;

    binary_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int prod;
    } vec_t;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected number of iterations for a given multiplier operand.
    function automatic int exp_iters(input int b);
`ifdef BINARY_MULTIPLIER_EARLY_TERM_EN
        int n = 1;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) n = i + 1;
        return n;
`else
        return (b < 0) ? 0 : WIDTH;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the capture edge until done; checks Product holds meanwhile.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (done) return;
            check("busy_during_run", busy, 1);
            check("product_held_during_run", Product, last_prod);
        end
        errors++;
        $display("FAIL wait_done: no done within 40 cycles, got busy=%0d", busy);
    endtask

    task automatic launch(input int a, input int b);
        A     = WIDTH'(a);
        B     = WIDTH'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input int a, input int b, input int exp_prod);
        int cyc;
        launch(a, b);
        check({name, "_busy_after_start"}, busy, 1);
        wait_done(cyc);
        check({name, "_latency"}, cyc, exp_iters(b));
        check({name, "_product"}, Product, exp_prod);
        check({name, "_busy_in_done"}, busy, 0);
        last_prod = Product;
    endtask

    initial begin
        vec_t vecs[10];
        int   cyc;
        int   a, b;

        checks    = 0;
        errors    = 0;
        last_prod = '0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;

        vecs[0] = '{3, 5, 15};   vecs[1] = '{15, 3, 45};
        vecs[2] = '{10, 4, 40};  vecs[3] = '{6, 6, 36};
        vecs[4] = '{1, 15, 15};  vecs[5] = '{5, 2, 10};
        vecs[6] = '{12, 3, 36};  vecs[7] = '{9, 5, 45};
        vecs[8] = '{0, 9, 0};    vecs[9] = '{15, 15, 225};

        // Reset held for two cycles.
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", Product, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_product", Product, 0);
        end

        // Directed table.
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod);

        // Result of 15x15 is held through idle cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_product", Product, 225);
            check("hold_done", done, 0);
            check("hold_busy", busy, 0);
        end

        // Random operands against plain arithmetic.
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, (1 << WIDTH) - 1));
            b = int'($urandom_range(0, (1 << WIDTH) - 1));
            run_op("rand", a, b, a * b);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Back-to-back: start during done cycle; a start pulse while busy is ignored.
        run_op("b2b_first", 3, 5, 15);
        launch(9, 5);
        check("b2b_second_busy", busy, 1);
        A = 4'd15; B = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        if (done) begin
            cyc = 1;
        end else begin
            check("b2b_hold", Product, 15);
            wait_done(cyc);
            cyc = cyc + 1;
        end
        check("b2b_latency", cyc, exp_iters(5));
        check("b2b_gap", cyc + 1, exp_iters(5) + 1);
        check("b2b_product", Product, 45);
        last_prod = Product;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_not_queued_busy", busy, 0);
            check("b2b_not_queued_done", done, 0);
        end

        // Reset mid-operation abandons the operation.
        launch(15, 15);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", Product, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_done", done, 0);
            check("midrst_product_held", Product, 0);
        end
        last_prod = '0;
        run_op("after_reset", 2, 3, 6);

        // Iteration count boundaries for B.
        run_op("b_zero", 7, 0, 0);
        run_op("b_one", 7, 1, 7);
        run_op("b_five", 7, 5, 35);
        run_op("b_max", 7, 15, 105);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got checks=%0d", checks);
        $fatal(1);
    end

endmodule : tb_binary_multiplier
`default_nettype wire
